// File: rtl/fft_stream_ctrl.sv
// Host-side streaming controller for fft_top: loads a frame into RAM_A, starts the core, streams results back.
// Optional build macro FFT_STREAM_TLAST_EN adds iS_LAST/oM_LAST with early frame end and zero padding.
module fft_stream_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic [DATA_W-1:0] iS_DATA,
   input  logic              iS_VALID,
   output logic              oS_READY,
`ifdef FFT_STREAM_TLAST_EN
   input  logic              iS_LAST,
   output logic              oM_LAST,
`endif
   output logic [DATA_W:0]   oM_DATA,
   output logic [ADDR_W+1:0] oM_INDEX,
   output logic              oM_VALID,
   input  logic              iM_READY,
   output logic [DATA_W-1:0] oFFT_DATA,
   output logic [ADDR_W-1:0] oFFT_ADDR_WR_0,
   output logic [ADDR_W-1:0] oFFT_ADDR_WR_1,
   output logic [ADDR_W-1:0] oFFT_ADDR_WR_2,
   output logic [ADDR_W-1:0] oFFT_ADDR_WR_3,
   output logic              oFFT_WE_0,
   output logic              oFFT_WE_1,
   output logic              oFFT_WE_2,
   output logic              oFFT_WE_3,
   output logic [ADDR_W-1:0] oFFT_ADDR_RD_0,
   output logic [ADDR_W-1:0] oFFT_ADDR_RD_1,
   output logic [ADDR_W-1:0] oFFT_ADDR_RD_2,
   output logic [ADDR_W-1:0] oFFT_ADDR_RD_3,
   input  logic [DATA_W:0]   iFFT_RE_0,
   input  logic [DATA_W:0]   iFFT_RE_1,
   input  logic [DATA_W:0]   iFFT_RE_2,
   input  logic [DATA_W:0]   iFFT_RE_3,
   output logic              oFFT_START,
   input  logic              iFFT_RDY,
   output logic              oBUSY,
   output logic              oDONE
);

   localparam int NW    = ADDR_W + 2;
   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [NW-1:0]     N_LAST = {NW{1'b1}};
   localparam logic [NW-1:0]     N_ONE  = NW'(1);
   localparam logic [ADDR_W-1:0] K_LAST = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] K_ONE  = ADDR_W'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_PAD, S_START, S_WAIT,
      S_RDADDR, S_RDLAT, S_CAPTURE, S_EMIT, S_DONE
   } state_t;

   state_t            state_q;
   logic [NW-1:0]     n_q;
   logic [NW-1:0]     n_d;
   logic [ADDR_W-1:0] k_q;
   logic [1:0]        b_q;
   logic [1:0]        b_d;
   logic [LAT_W-1:0]  lat_q;
   logic              rdy_prev_q;
   logic              start_q;
   logic              done_q;
   logic              m_valid_q;
   logic              m_last_q;
   logic [DATA_W:0]   m_data_q;
   logic [NW-1:0]     m_index_q;
   logic [DATA_W:0]   hold_q [4];

   logic [DATA_W:0]   re_in [4];
   logic [3:0]        we_vec;
   logic              s_accept;
   logic              pad_wr;
   logic              wr_phase;
   logic              rd_phase;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   assign n_d      = n_q + N_ONE;
   assign b_d      = b_q + 2'd1;
   assign s_accept = (state_q == S_LOAD) && iS_VALID;
   assign pad_wr   = (state_q == S_PAD);
   assign wr_phase = (state_q == S_LOAD) || (state_q == S_PAD);
   assign rd_phase = (state_q == S_RDADDR) || (state_q == S_RDLAT) || (state_q == S_CAPTURE);
   assign wr_addr  = wr_phase ? n_q[NW-1:2] : '0;
   assign rd_addr  = rd_phase ? k_q : '0;

   assign re_in[0] = iFFT_RE_0;
   assign re_in[1] = iFFT_RE_1;
   assign re_in[2] = iFFT_RE_2;
   assign re_in[3] = iFFT_RE_3;

   // Sample n lands in bank n[1:0]; padding writes reuse the same decode with zero data.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_we
         assign we_vec[gi] = (s_accept || pad_wr) && (n_q[1:0] == 2'(gi));
      end
   endgenerate

   assign oFFT_WE_0      = we_vec[0];
   assign oFFT_WE_1      = we_vec[1];
   assign oFFT_WE_2      = we_vec[2];
   assign oFFT_WE_3      = we_vec[3];
   assign oFFT_ADDR_WR_0 = wr_addr;
   assign oFFT_ADDR_WR_1 = wr_addr;
   assign oFFT_ADDR_WR_2 = wr_addr;
   assign oFFT_ADDR_WR_3 = wr_addr;
   assign oFFT_ADDR_RD_0 = rd_addr;
   assign oFFT_ADDR_RD_1 = rd_addr;
   assign oFFT_ADDR_RD_2 = rd_addr;
   assign oFFT_ADDR_RD_3 = rd_addr;
   assign oFFT_DATA      = (state_q == S_LOAD) ? iS_DATA : '0;
   assign oS_READY       = (state_q == S_LOAD);
   assign oBUSY          = (state_q != S_IDLE);
   assign oFFT_START     = start_q;
   assign oDONE          = done_q;
   assign oM_VALID       = m_valid_q;
   assign oM_DATA        = m_data_q;
   assign oM_INDEX       = m_index_q;
`ifdef FFT_STREAM_TLAST_EN
   assign oM_LAST        = m_last_q;
`endif

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         k_q        <= '0;
         b_q        <= '0;
         lat_q      <= '0;
         rdy_prev_q <= 1'b0;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
         m_index_q  <= '0;
         for (int i = 0; i < 4; i++) hold_q[i] <= '0;
      end else begin
         rdy_prev_q <= iFFT_RDY;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (iS_VALID) state_q <= S_LOAD;
            end
            S_LOAD: begin
               if (iS_VALID) begin
                  if (n_q == N_LAST) begin
                     n_q     <= '0;
                     start_q <= 1'b1;
                     state_q <= S_START;
`ifdef FFT_STREAM_TLAST_EN
                  end else if (iS_LAST) begin
                     n_q     <= n_d;
                     state_q <= S_PAD;
`endif
                  end else begin
                     n_q <= n_d;
                  end
               end
            end
            S_PAD: begin
               if (n_q == N_LAST) begin
                  n_q     <= '0;
                  start_q <= 1'b1;
                  state_q <= S_START;
               end else begin
                  n_q <= n_d;
               end
            end
            S_START: state_q <= S_WAIT;
            // Only a fresh 0->1 transition counts; a level left high from before START is ignored.
            S_WAIT: begin
               if (iFFT_RDY && !rdy_prev_q) state_q <= S_RDADDR;
            end
            S_RDADDR: begin
               lat_q   <= '0;
               state_q <= (RD_LAT == 0) ? S_CAPTURE : S_RDLAT;
            end
            S_RDLAT: begin
               if (lat_q == LAT_W'(RD_LAT - 1)) state_q <= S_CAPTURE;
               else                             lat_q   <= lat_q + LAT_W'(1);
            end
            S_CAPTURE: begin
               for (int i = 0; i < 4; i++) hold_q[i] <= re_in[i];
               m_data_q  <= re_in[0];
               m_index_q <= {k_q, 2'b00};
               m_valid_q <= 1'b1;
               m_last_q  <= 1'b0;
               b_q       <= 2'd0;
               state_q   <= S_EMIT;
            end
            S_EMIT: begin
               if (m_valid_q && iM_READY) begin
                  if (b_q != 2'd3) begin
                     b_q       <= b_d;
                     m_data_q  <= hold_q[b_d];
                     m_index_q <= {k_q, b_d};
                     m_last_q  <= (k_q == K_LAST) && (b_d == 2'd3);
                  end else begin
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                     b_q       <= 2'd0;
                     if (k_q == K_LAST) begin
                        k_q     <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        k_q     <= k_q + K_ONE;
                        state_q <= S_RDADDR;
                     end
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed bench for fft_stream_ctrl with a behavioural four-bank RAM standing in for fft_top.
// Build with FFT_STREAM_TLAST_EN defined to also exercise early frame end and oM_LAST.
module tb_fft_stream_ctrl;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 1;
   localparam int N      = 4 * (2 ** ADDR_W);
   localparam int K      = 2 ** ADDR_W;

   logic iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   logic              iRESET = 1'b1;
   logic [DATA_W-1:0] iS_DATA = '0;
   logic              iS_VALID = 1'b0;
   logic              oS_READY;
   logic [DATA_W:0]   oM_DATA;
   logic [ADDR_W+1:0] oM_INDEX;
   logic              oM_VALID;
   logic              iM_READY = 1'b1;
   logic [DATA_W-1:0] oFFT_DATA;
   logic [ADDR_W-1:0] wa0, wa1, wa2, wa3, ra0, ra1, ra2, ra3;
   logic              we0, we1, we2, we3;
   logic [DATA_W:0]   re_q [4];
   logic              oFFT_START;
   logic              iFFT_RDY = 1'b0;
   logic              oBUSY;
   logic              oDONE;
`ifdef FFT_STREAM_TLAST_EN
   logic              iS_LAST = 1'b0;
   logic              oM_LAST;
`endif

   fft_stream_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .iCLK(iCLK), .iRESET(iRESET),
      .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
`ifdef FFT_STREAM_TLAST_EN
      .iS_LAST(iS_LAST), .oM_LAST(oM_LAST),
`endif
      .oM_DATA(oM_DATA), .oM_INDEX(oM_INDEX), .oM_VALID(oM_VALID), .iM_READY(iM_READY),
      .oFFT_DATA(oFFT_DATA),
      .oFFT_ADDR_WR_0(wa0), .oFFT_ADDR_WR_1(wa1), .oFFT_ADDR_WR_2(wa2), .oFFT_ADDR_WR_3(wa3),
      .oFFT_WE_0(we0), .oFFT_WE_1(we1), .oFFT_WE_2(we2), .oFFT_WE_3(we3),
      .oFFT_ADDR_RD_0(ra0), .oFFT_ADDR_RD_1(ra1), .oFFT_ADDR_RD_2(ra2), .oFFT_ADDR_RD_3(ra3),
      .iFFT_RE_0(re_q[0]), .iFFT_RE_1(re_q[1]), .iFFT_RE_2(re_q[2]), .iFFT_RE_3(re_q[3]),
      .oFFT_START(oFFT_START), .iFFT_RDY(iFFT_RDY), .oBUSY(oBUSY), .oDONE(oDONE)
   );

   logic [3:0] we_v;
   assign we_v = {we3, we2, we1, we0};

   // Behavioural RAM_A: synchronous write, one-cycle registered read, sign-extended result.
   logic [DATA_W-1:0] ram [4][K];
   always @(posedge iCLK) begin
      if (we0) ram[0][wa0] <= oFFT_DATA;
      if (we1) ram[1][wa1] <= oFFT_DATA;
      if (we2) ram[2][wa2] <= oFFT_DATA;
      if (we3) ram[3][wa3] <= oFFT_DATA;
      re_q[0] <= {ram[0][ra0][DATA_W-1], ram[0][ra0]};
      re_q[1] <= {ram[1][ra1][DATA_W-1], ram[1][ra1]};
      re_q[2] <= {ram[2][ra2][DATA_W-1], ram[2][ra2]};
      re_q[3] <= {ram[3][ra3][DATA_W-1], ram[3][ra3]};
   end

   int err_cnt = 0;
   int chk_cnt = 0;
   int cyc = 0;
   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // mode 0: value n, mode 1: 0xFFFF-n (negative), mode 2: n^0x8000 below 1000, zero-padded above.
   function automatic logic [DATA_W-1:0] ld_val(input int mode, input int i);
      logic [15:0] iv;
      iv = i[15:0];
      case (mode)
         0:       return iv;
         1:       return 16'hFFFF - iv;
         default: return (i < 1000) ? (iv ^ 16'h8000) : 16'h0000;
      endcase
   endfunction

   function automatic logic [DATA_W:0] exp_val(input int mode, input int i);
      logic [DATA_W-1:0] f;
      f = ld_val(mode, i);
      return {f[DATA_W-1], f};
   endfunction

   int  mode = 0;
   bit  rnd_ready = 1'b0;
   int  start_cnt = 0, start_cyc = 0;
   int  done_cnt = 0, done_cyc = 0;
   int  out_cnt = 0, last_hs_cyc = 0;
   bit  first_seen = 1'b0;
   int  first_cyc = 0;
   int  acc_cyc = 0;
   bit  prev_stall = 1'b0;
   logic [DATA_W:0]   prev_data;
   logic [ADDR_W+1:0] prev_idx;

   always @(posedge iCLK) begin
      #1;
      iM_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor, sampled mid-cycle.
   always @(negedge iCLK) begin
      if (iRESET) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(oM_VALID), 32'd1);
            chk("stall_data", 32'(oM_DATA), 32'(prev_data));
            chk("stall_index", 32'(oM_INDEX), 32'(prev_idx));
         end
         if (oFFT_START) begin
            start_cnt++;
            start_cyc = cyc;
         end
         if (oDONE) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_last", 32'(out_cnt), 32'(N));
         end
         if (oM_VALID && !first_seen) begin
            first_seen = 1'b1;
            first_cyc  = cyc;
         end
         if (oM_VALID && iM_READY) begin
            chk("m_index", 32'(oM_INDEX), 32'(out_cnt));
            chk("m_data", 32'(oM_DATA), 32'(exp_val(mode, out_cnt)));
`ifdef FFT_STREAM_TLAST_EN
            chk("m_last", 32'(oM_LAST), 32'(out_cnt == N - 1));
`endif
            out_cnt++;
            last_hs_cyc = cyc;
         end
         prev_stall = oM_VALID && !iM_READY;
         prev_data  = oM_DATA;
         prev_idx   = oM_INDEX;
      end
   end

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] v, input bit gaps,
                       output logic [3:0] we_o, output logic [ADDR_W-1:0] wa_o);
      bit ok;
      ok = 1'b0;
      we_o = '0;
      wa_o = '0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      iS_DATA  = v;
      iS_VALID = 1'b1;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge iCLK);
         if (oS_READY) begin
            ok      = 1'b1;
            we_o    = we_v;
            wa_o    = wa0;
            acc_cyc = cyc;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      step();
      iS_VALID = 1'b0;
   endtask

   task automatic load_frame(input int m, input bit gaps, input int last_at);
      logic [3:0]        w;
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < N; i++) begin
`ifdef FFT_STREAM_TLAST_EN
         iS_LAST = (i == last_at);
`endif
         push(ld_val(m, i), gaps, w, a);
`ifdef FFT_STREAM_TLAST_EN
         iS_LAST = 1'b0;
`endif
         if (i == last_at) break;
      end
   endtask

   task automatic wait_start(input int budget);
      for (int t = 0; t < budget && start_cnt == 0; t++) step();
      repeat (3) step();
      chk("start_pulses", 32'(start_cnt), 32'd1);
   endtask

   task automatic wait_done(input int budget);
      for (int t = 0; t < budget && done_cnt == 0; t++) step();
      repeat (3) step();
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("out_count", 32'(out_cnt), 32'(N));
      chk("done_timing", 32'(done_cyc), 32'(last_hs_cyc + 1));
      chk("idle_after_done", 32'(oBUSY), 32'd0);
   endtask

   task automatic new_frame(input int m);
      mode = m; start_cnt = 0; done_cnt = 0; out_cnt = 0; first_seen = 1'b0;
   endtask

   initial begin
      logic [3:0]        w;
      logic [ADDR_W-1:0] a;
      int                mism;
      int                rise_cyc;

      repeat (3) @(posedge iCLK);
      #1;
      iRESET = 1'b0;
      @(negedge iCLK);
      chk("rst_busy", 32'(oBUSY), 32'd0);
      chk("rst_s_ready", 32'(oS_READY), 32'd0);
      chk("rst_start", 32'(oFFT_START), 32'd0);
      chk("rst_m_valid", 32'(oM_VALID), 32'd0);
      chk("rst_done", 32'(oDONE), 32'd0);
      chk("rst_we", 32'(we_v), 32'd0);
      chk("rst_m_data", 32'(oM_DATA), 32'd0);
      step();

      // Abort a frame after 37 accepted samples.
      new_frame(0);
      for (int i = 0; i < 37; i++) push(16'h1234, 1'b0, w, a);
      iRESET = 1'b1;
      repeat (2) step();
      iRESET = 1'b0;
      @(negedge iCLK);
      chk("abort_busy", 32'(oBUSY), 32'd0);
      chk("abort_we", 32'(we_v), 32'd0);
      chk("abort_start", 32'(oFFT_START), 32'd0);
      chk("abort_no_start", 32'(start_cnt), 32'd0);
      step();
      $display("frame abort: 37 samples then reset");

      // Full frame with ready already high before START.
      new_frame(0);
      iFFT_RDY = 1'b1;
      push(ld_val(0, 0), 1'b0, w, a);
      chk("restart_we", 32'(w), 32'h1);
      chk("restart_addr", 32'(a), 32'd0);
      for (int i = 1; i < N; i++) push(ld_val(0, i), 1'b0, w, a);
      chk("last_sample_we", 32'(w), 32'h8);
      chk("last_sample_addr", 32'(a), 32'(K - 1));
      wait_start(10);
      chk("start_timing", 32'(start_cyc), 32'(acc_cyc + 1));
      mism = 0;
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < K; k++)
            if (ram[b][k] !== 16'(4 * k + b)) mism++;
      chk("load_map", 32'(mism), 32'd0);
      chk("ram_b3_last", 32'(ram[3][K-1]), 32'(N - 1));
      chk("ram_b1_a0", 32'(ram[1][0]), 32'd1);
      iS_VALID = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge iCLK);
         chk("wait_s_ready", 32'(oS_READY), 32'd0);
         chk("wait_we", 32'(we_v), 32'd0);
         chk("wait_no_output", 32'(oM_VALID), 32'd0);
         chk("wait_busy", 32'(oBUSY), 32'd1);
         step();
      end
      iS_VALID = 1'b0;
      iFFT_RDY = 1'b0;
      step();
      iFFT_RDY = 1'b1;
      rise_cyc = cyc;
      for (int t = 0; t < 20 && !first_seen; t++) step();
      chk("rdy_edge_latency", 32'(first_cyc), 32'(rise_cyc + 4));
      wait_done(6000);
      iFFT_RDY = 1'b0;
      $display("frame 0: %0d results, linear data", out_cnt);

      // Random source gaps and sink backpressure, negative data.
      new_frame(1);
      load_frame(1, 1'b1, N - 1);
      wait_start(10);
      repeat (2) step();
      iFFT_RDY = 1'b1;
      rnd_ready = 1'b1;
      wait_done(30000);
      rnd_ready = 1'b0;
      iFFT_RDY = 1'b0;
      $display("frame 1: %0d results under backpressure", out_cnt);

`ifdef FFT_STREAM_TLAST_EN
      new_frame(2);
      load_frame(2, 1'b0, 999);
      wait_start(N + 10);
      chk("pad_start_timing", 32'(start_cyc), 32'(acc_cyc + (N - 1000) + 1));
      mism = 0;
      for (int i = 0; i < N; i++)
         if (ram[i % 4][i / 4] !== ld_val(2, i)) mism++;
      chk("pad_map", 32'(mism), 32'd0);
      repeat (2) step();
      iFFT_RDY = 1'b1;
      wait_done(6000);
      iFFT_RDY = 1'b0;
      $display("frame 2: %0d results, early last at 999", out_cnt);
`endif

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
